// File: rtl/acq_frame_ctrl.sv
// acq_frame_ctrl: frame tick generator with decimated capture into a time buffer.
// Define ACQ_FRAME_TRIGGER_EN for a level-triggered ARM state ahead of capture.
module acq_frame_ctrl #(
   parameter int CLK_HZ   = 100000000,
   parameter int FRAME_HZ = 10,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 1024,
   parameter int ADDR_W   = 10,
   parameter int DECIM_W  = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [DECIM_W-1:0] decim,
   input  logic               sample_valid,
   input  logic [DATA_W-1:0]  sample_data,
`ifdef ACQ_FRAME_TRIGGER_EN
   input  logic [DATA_W-1:0]  trig_level,
`endif
   output logic               buf_en,
   output logic               buf_we,
   output logic [ADDR_W-1:0]  buf_addr,
   output logic [DATA_W-1:0]  buf_din,
   output logic               frame_start,
   output logic               frame_done,
   output logic               busy,
   output logic [7:0]         overrun_cnt
);

   localparam int PRESC = CLK_HZ / FRAME_HZ;
   localparam int PW    = $clog2(PRESC);

`ifdef ACQ_FRAME_TRIGGER_EN
   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
   localparam state_t START = ARM;
`else
   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
   localparam state_t START = CAPTURE;
`endif

   state_t             state, state_n;
   logic               rst_m, rst_s;
   logic [PW-1:0]      pcnt;
   logic               tick;
   logic [ADDR_W-1:0]  addr;
   logic [DECIM_W-1:0] dcnt, decim_q;
   logic               last_wr, wr, step, load;

   // release is re-timed to clk; assertion stays asynchronous
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_m <= 1'b0;
         rst_s <= 1'b0;
      end else begin
         rst_m <= 1'b1;
         rst_s <= rst_m;
      end
   end

   assign tick    = (pcnt == PW'(PRESC - 1));
   assign last_wr = buf_we && (buf_addr == ADDR_W'(DEPTH - 1));

`ifdef ACQ_FRAME_TRIGGER_EN
   logic [DATA_W:0] mag;
   logic            hit;

   always_comb begin
      mag = {1'b0, sample_data};
      if (sample_data[DATA_W-1])
         mag = {1'b0, ~sample_data} + (DATA_W+1)'(1);
      hit = sample_valid && (mag >= {1'b0, trig_level});
   end
`endif

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) state <= IDLE;
      else        state <= state_n;
   end

   // last write must see buf_en high, so DONE follows it by a cycle
   always_comb begin
      state_n = state;
      wr      = 1'b0;
      step    = 1'b0;
      load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick && enable) begin
               state_n = START;
               load    = 1'b1;
            end
         end
`ifdef ACQ_FRAME_TRIGGER_EN
         ARM: begin
            if (!enable) begin
               state_n = IDLE;
            end else if (hit) begin
               state_n = CAPTURE;
               wr      = 1'b1;
               step    = 1'b1;
            end else if (tick) begin
               load = 1'b1;
            end
         end
`endif
         CAPTURE: begin
            if (!enable) begin
               state_n = IDLE;
            end else if (last_wr) begin
               state_n = DONE;
            end else if (sample_valid) begin
               step = 1'b1;
               wr   = (dcnt == '0);
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         pcnt        <= '0;
         addr        <= '0;
         dcnt        <= '0;
         decim_q     <= '0;
         buf_we      <= 1'b0;
         buf_addr    <= '0;
         buf_din     <= '0;
         frame_start <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         pcnt        <= tick ? '0 : pcnt + 1'b1;
         buf_we      <= wr;
         frame_start <= (state_n == CAPTURE) && (state != CAPTURE);
         if (tick && state != IDLE && overrun_cnt != 8'hff)
            overrun_cnt <= overrun_cnt + 1'b1;
         if (load) begin
            addr    <= '0;
            dcnt    <= '0;
            decim_q <= decim;
         end
         if (step)
            dcnt <= (dcnt == decim_q) ? '0 : dcnt + 1'b1;
         if (wr) begin
            buf_addr <= addr;
            buf_din  <= sample_data;
            addr     <= addr + 1'b1;
         end
      end
   end

   assign buf_en     = (state == CAPTURE);
   assign frame_done = (state == DONE);
   assign busy       = (state != IDLE);

endmodule
